mem_lanes: RTL



---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_lane_ram.sv | 47 ++++
 rtl/mem_lanes.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the multi-lane LC-3b memory.
//   state_t   : controller states (sweep clear, idle, latency wait)
//   SIZE_*    : encoding of the size input
//   lane_bits : number of address bits that select a lane within a row
package mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    function automatic int lane_bits(input int lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/mem_lane_ram.sv
// Row-organised storage for mem_lanes: ROWS rows of LANES lanes each.
// Ports:
//   clk      in   clock (posedge)
//   we_mask  in   per-lane write enable for row wr_row
//   wr_row   in   row written this edge
//   wdata    in   row-wide write data; lane i takes bits [i*LANE_W +: LANE_W]
//   rd_row   in   row read this edge
//   rdata    out  registered contents of rd_row (one-cycle synchronous read,
//                 read-before-write when rd_row == wr_row)
module mem_lane_ram
    import mem_pkg::*;
#(
    parameter int ROW_W  = 8,
    parameter int LANES  = 2,
    parameter int LANE_W = 8
) (
    input  logic                      clk,
    input  logic [LANES-1:0]          we_mask,
    input  logic [ROW_W-1:0]          wr_row,
    input  logic [LANES*LANE_W-1:0]   wdata,
    input  logic [ROW_W-1:0]          rd_row,
    output logic [LANES*LANE_W-1:0]   rdata
);

    localparam int ROWS   = 1 << ROW_W;
    localparam int DATA_W = LANES * LANE_W;

    logic [DATA_W-1:0] mem_q [ROWS];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        rdata_d = mem_q[rd_row];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we_mask[i]) begin
                mem_q[wr_row][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_lanes.sv
// Byte-addressed multi-lane RAM for the LC-3b datapath with byte and word
// access, a programmable-latency request/ready handshake and a clear sweep
// after reset that zeroes every row and loads BOOT_WORD into row 0.
// Ports:
//   clk    in   clock (posedge)
//   reset  in   synchronous, active-high; aborts any in-flight access
//   req    in   access request
//   we     in   1 = write, 0 = read
//   size   in   0 = byte, 1 = full row
//   addr   in   byte address (low log2(LANES) bits select the lane)
//   wdata  in   write data; byte writes use lane-0 bits
//   rdata  out  read data, held until the next read completes or reset
//   ready  out  one-cycle completion pulse
//   busy   out  high while the clear sweep runs
//
// Handshake: req is a level the requester holds until it sees ready. An
// access is accepted on an IDLE edge with req = 1; the inputs are latched
// there and ignored until ready pulses LATENCY edges later. A requester
// that still holds req in the cycle after ready gets a new access accepted,
// so it must drop req during the ready cycle to avoid a repeat.
module mem_lanes
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LANES   = 2,
    parameter int LANE_W  = 8,
    parameter int LATENCY = 4,
    parameter logic [LANES*LANE_W-1:0] BOOT_WORD = (LANES*LANE_W)'(16'h0001)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req,
    input  logic                      we,
    input  logic                      size,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [LANES*LANE_W-1:0]   wdata,
    output logic [LANES*LANE_W-1:0]   rdata,
    output logic                      ready,
    output logic                      busy
);

    localparam int LB     = lane_bits(LANES);
    localparam int ROW_W  = ADDR_W - LB;
    localparam int ROWS   = 1 << ROW_W;
    localparam int DATA_W = LANES * LANE_W;
    localparam int CNT_W  = $clog2(LATENCY + 1);

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    clr_ptr_q, clr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic [LANES-1:0]    ram_mask;
    logic [ROW_W-1:0]    ram_wrow;
    logic [DATA_W-1:0]   ram_wdata;
    logic [ROW_W-1:0]    ram_rrow;
    logic [DATA_W-1:0]   ram_rdata;
    logic [LANE_W-1:0]   byte_val;

    mem_lane_ram #(
        .ROW_W  (ROW_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_ram (
        .clk     (clk),
        .we_mask (ram_mask),
        .wr_row  (ram_wrow),
        .wdata   (ram_wdata),
        .rd_row  (ram_rrow),
        .rdata   (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        busy_d    = busy_q;

        ram_mask  = '0;
        ram_wrow  = clr_ptr_q;
        ram_wdata = '0;
        // The RAM read is one cycle deep, so the row is presented on the
        // accepting edge (from the live addr) and kept during WAIT (from the
        // latched addr); its output is then valid by the completion edge
        // even when LATENCY = 1.
        ram_rrow  = addr[ADDR_W-1:LB];
        byte_val  = ram_rdata[int'(addr_q[LB-1:0]) * LANE_W +: LANE_W];

        case (state_q)
            CLEAR: begin
                ram_mask  = '1;
                ram_wrow  = clr_ptr_q;
                ram_wdata = (clr_ptr_q == '0) ? BOOT_WORD : '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ROW_W'(ROWS - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                ram_rrow = addr_q[ADDR_W-1:LB];
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    if (we_q) begin
                        ram_wrow = addr_q[ADDR_W-1:LB];
                        if (size_q == SIZE_WORD) begin
                            ram_mask  = '1;
                            ram_wdata = wdata_q;
                        end else begin
                            ram_mask  = LANES'(1) << addr_q[LB-1:0];
                            ram_wdata = {LANES{wdata_q[LANE_W-1:0]}};
                        end
                    end else if (size_q == SIZE_WORD) begin
                        rdata_d = ram_rdata;
                    end else begin
                        rdata_d = '0;
                        rdata_d[LANE_W-1:0] = byte_val;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        // A write completing on the reset edge must not reach the array.
        if (reset) begin
            ram_mask = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            size_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule
